// File: rtl/tm11_gen.sv
// TM11/TU10 magtape register block: Unibus slave, ARM shadow-register port and interrupt FSM.
// Build option: define TM11_GEN_REWIRQ_EN to request an interrupt when the ARM ends a rewind.
module tm11_gen #(
    parameter logic [17:0] ADDR   = 18'o772520,
    parameter logic [7:0]  INTVEC = 8'o224,
    parameter int unsigned NDRV   = 8,
    parameter int unsigned RDHALF = 500000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        armwrite,
    input  logic [2:0]  armraddr,
    input  logic [2:0]  armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    output logic        armintrq,
    output logic        intreq,
    output logic [7:0]  irvec,
    input  logic        intgnt,
    input  logic [7:0]  igvec,
    input  logic [17:0] a_in_h,
    input  logic [1:0]  c_in_h,
    input  logic [15:0] d_in_h,
    input  logic        init_in_h,
    input  logic        msyn_in_h,
    output logic [15:0] d_out_h,
    output logic        ssyn_out_h
);

    localparam int unsigned DMASK_I = (1 << NDRV) - 1;
    localparam logic [7:0]  DMASK   = DMASK_I[7:0];
    localparam int unsigned TW      = (RDHALF > 1) ? $clog2(RDHALF) : 1;
    localparam logic [TW-1:0] TLAST = TW'(RDHALF - 1);

    typedef enum logic [0:0] {StIdle, StPend} irq_st_e;

    logic          enable_q, fastio_q, init_q;
    logic [15:7]   mts_hi_q;
    logic [14:0]   mtc_q;
    logic [15:0]   brc_q, cma_q, mtd_q;
    logic [14:0]   mtrd_q;
    logic [TW-1:0] rd_cnt_q;
    logic          rd_tog_q;
    logic [7:0]    bots_q, wrls_q, rews_q, turs_q, sels_q;
    logic [15:0]   d_out_q;
    logic          ssyn_q;
    irq_st_e       irq_st_q;
    logic          intreq_q, lvl_q;

    logic [2:0]  unit, nu;
    logic        unit_ok, nu_ok, go_req;
    logic [6:0]  mts_lo;
    logic [15:0] mts;
    logic        mtc15, lvl, post_init;
    logic        ub_sel, ub_start, ub_lo, ub_hi;
    logic [15:0] ub_rdata;
    logic        rew_kick;

    assign unit    = mtc_q[10:8];
    assign unit_ok = {29'd0, unit} < NDRV;
    assign mts_lo  = unit_ok ? {sels_q[unit], bots_q[unit], 2'b00, wrls_q[unit], rews_q[unit],
                                turs_q[unit]} : 7'd0;
    assign mts     = {mts_hi_q, mts_lo};
    assign mtc15   = |mts_hi_q;
    assign lvl     = mtc_q[7] & mtc_q[6];
    assign post_init = init_q & ~init_in_h;

    // Unibus decode; offsets 14/16 octal fall outside the responding window
    assign ub_sel   = enable_q && (a_in_h[17:4] == ADDR[17:4]) && (a_in_h[3:1] <= 3'd5);
    assign ub_start = ub_sel & msyn_in_h & ~ssyn_q;
    assign ub_lo    = ~c_in_h[0] | ~a_in_h[0];
    assign ub_hi    = ~c_in_h[0] | a_in_h[0];

    // Unit targeted by an MTC write: the new unit field if the high byte is written
    assign nu     = ub_hi ? d_in_h[10:8] : mtc_q[10:8];
    assign nu_ok  = {29'd0, nu} < NDRV;
    assign go_req = ub_lo & d_in_h[0] & ~mtc_q[0];

    always_comb begin
        ub_rdata = 16'd0;
        case (a_in_h[3:1])
            3'd0:    ub_rdata = mts;
            3'd1:    ub_rdata = {mtc15, mtc_q & 15'o67776};
            3'd2:    ub_rdata = brc_q;
            3'd3:    ub_rdata = {cma_q[15:1], 1'b0};
            3'd4:    ub_rdata = mtd_q;
            3'd5:    ub_rdata = {rd_tog_q, mtrd_q};
            default: ub_rdata = 16'd0;
        endcase
    end

    always_comb begin
        armrdata = 32'd0;
        case (armraddr)
            3'd0:    armrdata = 32'h544D_3007;
            3'd1:    armrdata = {mtc15, mtc_q, mts};
            3'd2:    armrdata = {cma_q, brc_q};
            3'd3:    armrdata = {rd_tog_q, mtrd_q, mtd_q};
            3'd4:    armrdata = {enable_q, fastio_q, 4'b0000, INTVEC, ADDR};
            3'd5:    armrdata = {bots_q, wrls_q, rews_q, turs_q};
            3'd6:    armrdata = {24'd0, sels_q};
            default: armrdata = 32'hDEAD_BEEF;
        endcase
    end

`ifdef TM11_GEN_REWIRQ_EN
    logic [7:0] rews_new;
    assign rews_new = armwdata[15:8] & DMASK;
    assign rew_kick = armwrite && !init_in_h && !post_init && (armwaddr == 3'd5) && lvl &&
                      unit_ok && rews_q[unit] && !rews_new[unit];
`else
    assign rew_kick = 1'b0;
`endif

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            enable_q <= 1'b0;
            fastio_q <= 1'b0;
            rd_cnt_q <= '0;
            rd_tog_q <= 1'b0;
        end else begin
            if (rd_cnt_q == TLAST) begin
                rd_cnt_q <= '0;
                rd_tog_q <= ~rd_tog_q;
            end else begin
                rd_cnt_q <= rd_cnt_q + 1'b1;
            end
            if (armwrite && !init_in_h && !post_init && armwaddr == 3'd4) begin
                {enable_q, fastio_q} <= armwdata[31:30];
            end
        end
    end

    // Drive status bits are deliberately not reset; the ARM daemon owns them
    always_ff @(posedge CLOCK) begin
        init_q <= init_in_h & ~RESET;
        if (RESET || init_in_h) begin
            mts_hi_q <= '0;
            mtc_q    <= '0;
            d_out_q  <= '0;
            ssyn_q   <= 1'b0;
        end else if (post_init) begin
            mtc_q  <= 15'o10200;
            brc_q  <= '0;
            cma_q  <= '0;
            mtd_q  <= '0;
            mtrd_q <= '0;
        end else if (armwrite) begin
            case (armwaddr)
                3'd1: begin
                    mtc_q    <= armwdata[30:16];
                    mts_hi_q <= {mts_hi_q[15] | armwdata[15], armwdata[14:7]};
                end
                3'd2: begin
                    cma_q <= {armwdata[31:17], 1'b0};
                    brc_q <= armwdata[15:0];
                end
                3'd3: begin
                    mtrd_q <= armwdata[30:16];
                    mtd_q  <= armwdata[15:0];
                end
                3'd5: begin
                    bots_q <= armwdata[31:24] & DMASK;
                    wrls_q <= armwdata[23:16] & DMASK;
                    rews_q <= armwdata[15:8] & DMASK;
                    turs_q <= armwdata[7:0] & DMASK;
                end
                3'd6:    sels_q <= armwdata[7:0] & DMASK;
                default: ;
            endcase
        end else if (ssyn_q) begin
            if (!msyn_in_h) begin
                ssyn_q  <= 1'b0;
                d_out_q <= '0;
            end
        end else if (ub_start) begin
            ssyn_q <= 1'b1;
            if (!c_in_h[1]) begin
                d_out_q <= ub_rdata;
            end else begin
                case (a_in_h[3:1])
                    3'd1: begin
                        if (ub_hi && d_in_h[12]) begin
                            // Power clear via the PCLR bit
                            mts_hi_q    <= '0;
                            mtc_q[14:8] <= d_in_h[14:8];
                            mtc_q[7]    <= 1'b1;
                            mtc_q[0]    <= 1'b0;
                            if (ub_lo) mtc_q[6:1] <= d_in_h[6:1];
                        end else if (!mtc_q[7]) begin
                            mts_hi_q[15] <= 1'b1;
                        end else begin
                            if (ub_hi) mtc_q[14:8] <= d_in_h[14:8];
                            if (ub_lo) mtc_q[6:1] <= d_in_h[6:1];
                            if (go_req) begin
                                if (!nu_ok) begin
                                    mts_hi_q[15] <= 1'b1;
                                end else begin
                                    mtc_q[0]   <= 1'b1;
                                    mtc_q[7]   <= 1'b0;
                                    mts_hi_q   <= '0;
                                    turs_q[nu] <= 1'b0;
                                end
                            end
                        end
                    end
                    3'd2: begin
                        if (ub_lo) brc_q[7:0] <= d_in_h[7:0];
                        if (ub_hi) brc_q[15:8] <= d_in_h[15:8];
                    end
                    3'd3: begin
                        if (ub_lo) cma_q[7:0] <= {d_in_h[7:1], 1'b0};
                        if (ub_hi) cma_q[15:8] <= d_in_h[15:8];
                    end
                    3'd4: begin
                        if (ub_lo) mtd_q[7:0] <= d_in_h[7:0];
                        if (ub_hi) mtd_q[15:8] <= d_in_h[15:8];
                    end
                    3'd5: begin
                        if (ub_lo) mtrd_q[7:0] <= d_in_h[7:0];
                        if (ub_hi) mtrd_q[14:8] <= d_in_h[14:8];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET || init_in_h) begin
            irq_st_q <= StIdle;
            intreq_q <= 1'b0;
            lvl_q    <= 1'b0;
        end else begin
            lvl_q <= lvl;
            case (irq_st_q)
                StIdle: begin
                    if ((lvl && !lvl_q) || rew_kick) begin
                        irq_st_q <= StPend;
                        intreq_q <= 1'b1;
                    end
                end
                StPend: begin
                    if ((intgnt && igvec == INTVEC) || !lvl) begin
                        irq_st_q <= StIdle;
                        intreq_q <= 1'b0;
                    end
                end
                default: begin
                    irq_st_q <= StIdle;
                    intreq_q <= 1'b0;
                end
            endcase
        end
    end

    assign intreq     = intreq_q;
    assign irvec      = intreq_q ? INTVEC : 8'd0;
    assign armintrq   = mtc_q[0] | mtc_q[12];
    assign d_out_h    = d_out_q;
    assign ssyn_out_h = ssyn_q;

endmodule

// File: tb/tb_tm11_gen.sv
// Directed bench for tm11_gen (NDRV=2, RDHALF=4) with a queue-based scoreboard for register reads.
module tb_tm11_gen;

    logic        CLOCK = 1'b0, RESET = 1'b1;
    logic        armwrite = 1'b0;
    logic [2:0]  armraddr = 3'd0, armwaddr = 3'd0;
    logic [31:0] armwdata = 32'd0, armrdata;
    logic        armintrq, intreq, intgnt = 1'b0;
    logic [7:0]  irvec, igvec = 8'd0;
    logic [17:0] a_in_h = 18'd0;
    logic [1:0]  c_in_h = 2'd0;
    logic [15:0] d_in_h = 16'd0, d_out_h;
    logic        init_in_h = 1'b0, msyn_in_h = 1'b0, ssyn_out_h;

    int checks = 0, errors = 0, cyc = 0;
    logic [31:0] exp_q[$];

    localparam logic [31:0] ID4 = {2'b00, 4'b0000, 8'o224, 18'o772520};
`ifdef TM11_GEN_REWIRQ_EN
    localparam logic REWIRQ = 1'b1;
`else
    localparam logic REWIRQ = 1'b0;
`endif

    tm11_gen #(.NDRV(2), .RDHALF(4)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .armwrite(armwrite), .armraddr(armraddr),
        .armwaddr(armwaddr), .armwdata(armwdata), .armrdata(armrdata), .armintrq(armintrq),
        .intreq(intreq), .irvec(irvec), .intgnt(intgnt), .igvec(igvec), .a_in_h(a_in_h),
        .c_in_h(c_in_h), .d_in_h(d_in_h), .init_in_h(init_in_h), .msyn_in_h(msyn_in_h),
        .d_out_h(d_out_h), .ssyn_out_h(ssyn_out_h)
    );

    always #5 CLOCK = ~CLOCK;
    always @(posedge CLOCK) cyc <= RESET ? 0 : cyc + 1;

    // Timer model: bit toggles after every 4 clocks since reset released
    function automatic logic tog();
        return ((cyc / 4) % 2) == 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic arm_wr(input logic [2:0] idx, input logic [31:0] data);
        armwrite = 1'b1; armwaddr = idx; armwdata = data;
        @(negedge CLOCK);
        armwrite = 1'b0;
    endtask

    task automatic arm_rd(input logic [2:0] idx, input logic [31:0] expv, input string tag);
        exp_q.push_back(expv);
        armraddr = idx;
        #1;
        check(tag, armrdata, exp_q.pop_front());
    endtask

    task automatic ub_wr(input logic [17:0] a, input logic byte_op, input logic [15:0] d,
                         input string tag);
        a_in_h = a; c_in_h = {1'b1, byte_op}; d_in_h = d; msyn_in_h = 1'b1;
        @(negedge CLOCK);
        check({tag, "_ssyn"}, {31'd0, ssyn_out_h}, 32'd1);
        msyn_in_h = 1'b0;
        @(negedge CLOCK);
        check({tag, "_rel"}, {31'd0, ssyn_out_h}, 32'd0);
    endtask

    task automatic ub_rd(input logic [17:0] a, input logic [15:0] expv, input string tag);
        exp_q.push_back({16'd0, expv});
        a_in_h = a; c_in_h = 2'b00; msyn_in_h = 1'b1;
        @(negedge CLOCK);
        check({tag, "_ssyn"}, {31'd0, ssyn_out_h}, 32'd1);
        check(tag, {16'd0, d_out_h}, exp_q.pop_front());
        msyn_in_h = 1'b0;
        @(negedge CLOCK);
        check({tag, "_clr"}, {15'd0, ssyn_out_h, d_out_h}, 32'd0);
    endtask

    task automatic ub_none(input logic [17:0] a, input string tag);
        a_in_h = a; c_in_h = 2'b00; msyn_in_h = 1'b1;
        repeat (3) @(negedge CLOCK);
        check(tag, {15'd0, ssyn_out_h, d_out_h}, 32'd0);
        msyn_in_h = 1'b0;
        @(negedge CLOCK);
    endtask

    task automatic wait_irq(input logic lvl, input string tag);
        for (int n = 0; n < 4 && intreq !== lvl; n++) @(negedge CLOCK);
        check(tag, {31'd0, intreq}, {31'd0, lvl});
    endtask

    task automatic grant(input logic [7:0] vec);
        intgnt = 1'b1; igvec = vec;
        @(negedge CLOCK);
        intgnt = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge CLOCK);
        check("rst_intreq", {31'd0, intreq}, 32'd0);
        check("rst_ub", {15'd0, ssyn_out_h, d_out_h}, 32'd0);
        arm_rd(3'd4, ID4, "rst_idx4");
        RESET = 1'b0;

        // Drive bits at or above NDRV read back as zero
        arm_wr(3'd5, 32'hFFFF_FFFF);
        arm_rd(3'd5, 32'h0303_0303, "drv_mask5");
        arm_wr(3'd6, 32'h0000_00FF);
        arm_rd(3'd6, 32'h0000_0003, "drv_mask6");
        arm_wr(3'd5, 32'd0);
        arm_wr(3'd6, 32'd0);
        arm_rd(3'd0, 32'h544D_3007, "id");
        arm_rd(3'd7, 32'hDEAD_BEEF, "idx7");

        init_in_h = 1'b1;
        @(negedge CLOCK);
        init_in_h = 1'b0;
        @(negedge CLOCK);
        arm_rd(3'd1, 32'h1080_0000, "post_init");
        check("init_armintrq", {31'd0, armintrq}, 32'd1);
        check("init_intreq", {31'd0, intreq}, 32'd0);

        ub_none(18'o772520, "disabled_pre");
        arm_wr(3'd4, 32'h8000_0000);
        arm_rd(3'd4, ID4 | 32'h8000_0000, "enable");

        // GO to nonexistent unit 3
        ub_wr(18'o772522, 1'b0, 16'o001401, "mtc_bad_unit");
        arm_rd(3'd1, 32'h8380_8000, "bad_unit_idx1");
        check("bad_unit_armintrq", {31'd0, armintrq}, 32'd0);
        ub_rd(18'o772520, 16'o100000, "mts_ilc");
        ub_rd(18'o772522, 16'o101600, "mtc_rd");

        // Good GO to unit 0
        arm_wr(3'd5, 32'h0000_0001);
        ub_wr(18'o772522, 1'b0, 16'o000101, "mtc_go");
        arm_rd(3'd1, 32'h0041_0000, "go_idx1");
        arm_rd(3'd5, 32'd0, "go_turs");
        check("go_armintrq", {31'd0, armintrq}, 32'd1);
        ub_wr(18'o772522, 1'b0, 16'o000100, "mtc_busy");
        ub_rd(18'o772522, 16'o100100, "busy_ilc");

        // Interrupt on RDY rising with IE set
        arm_wr(3'd1, 32'h00C0_0000);
        wait_irq(1'b1, "irq_raise");
        check("irvec", {24'd0, irvec}, {24'd0, 8'o224});
        check("armintrq_done", {31'd0, armintrq}, 32'd0);
        grant(8'o230);
        check("foreign_grant", {31'd0, intreq}, 32'd1);
        grant(8'o224);
        check("grant_clr", {31'd0, intreq}, 32'd0);
        check("irvec_clr", {24'd0, irvec}, 32'd0);
        repeat (3) @(negedge CLOCK);
        check("no_rerequest", {31'd0, intreq}, 32'd0);

        // Level drops before a grant withdraws the request
        arm_wr(3'd1, 32'h0040_0000);
        arm_wr(3'd1, 32'h00C0_0000);
        wait_irq(1'b1, "irq_raise2");
        arm_wr(3'd1, 32'h0040_0000);
        wait_irq(1'b0, "irq_withdraw");

        // Byte lanes and MTCMA bit 0
        ub_wr(18'o772527, 1'b1, 16'o177777, "cma_hi");
        ub_rd(18'o772526, 16'o177400, "cma_hi_rd");
        ub_wr(18'o772526, 1'b1, 16'o177777, "cma_lo");
        ub_rd(18'o772526, 16'o177776, "cma_lo_rd");
        ub_wr(18'o772524, 1'b0, 16'o123456, "brc_word");
        ub_rd(18'o772524, 16'o123456, "brc_word_rd");
        ub_wr(18'o772524, 1'b1, 16'o000377, "brc_lo");
        ub_rd(18'o772524, 16'o123777, "brc_lo_rd");
        ub_none(18'o772534, "offset14");
        ub_none(18'o772540, "addr_miss");

        // Read-rate timer
        arm_rd(3'd3, {tog(), 31'd0}, "timer_a");
        repeat (2) @(negedge CLOCK);
        arm_rd(3'd3, {tog(), 31'd0}, "timer_b");
        repeat (3) @(negedge CLOCK);
        arm_rd(3'd3, {tog(), 31'd0}, "timer_c");
        ub_rd(18'o772532, {tog(), 15'd0}, "mtrd_ub");
        @(negedge CLOCK);
        ub_rd(18'o772532, {tog(), 15'd0}, "mtrd_ub2");

        // Rewind completion with RDY&IE already high
        arm_wr(3'd5, 32'h0000_0100);
        arm_wr(3'd1, 32'h00C0_0000);
        wait_irq(1'b1, "irq_raise3");
        grant(8'o224);
        check("grant_clr3", {31'd0, intreq}, 32'd0);
        arm_wr(3'd5, 32'd0);
        check("rew_irq", {31'd0, intreq}, {31'd0, REWIRQ});
        repeat (2) @(negedge CLOCK);
        check("rew_irq_hold", {31'd0, intreq}, {31'd0, REWIRQ});
        if (REWIRQ) grant(8'o224);
        wait_irq(1'b0, "rew_irq_clr");

        // Power clear through MTC
        ub_wr(18'o772522, 1'b0, 16'o010000, "pclr");
        ub_rd(18'o772522, 16'o000200, "pclr_rd");
        check("pclr_armintrq", {31'd0, armintrq}, 32'd1);
        arm_wr(3'd5, 32'h0101_0000);
        arm_wr(3'd6, 32'h0000_0001);
        ub_rd(18'o772520, 16'o000144, "mts_status");

        arm_wr(3'd4, 32'd0);
        ub_none(18'o772520, "disabled_post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
